hazard_ctrl: RTL
================

Name: hazard_ctrl

Overview:
- Decode-stage hazard and stall controller for the 5-stage MIPS pipeline.
- Complements the EX-stage forwarding unit. It handles the hazards forwarding cannot resolve:
  - load-use dependencies
  - accesses to a multi-cycle MUL/DIV unit
  - taken-branch squashes
- Drives PC/IF_ID write enables and the IF_ID/ID_EX flush controls.
- Owns the MUL/DIV busy sequencer and a stall performance counter.

Parameters:
- MD_LAT, 4, MUL/DIV latency in cycles; legal range 2..16.
- CNT_W, 32, width of the stall performance counter.

Ports:
- clk  input  1  pipeline clock, rising edge
- rst  input  1  synchronous, active-high reset
- ID_Rs  input  5  Rs field of the instruction in ID
- ID_Rt  input  5  Rt field of the instruction in ID
- ID_UseRs  input  1  ID instruction reads Rs
- ID_UseRt  input  1  ID instruction reads Rt
- ID_MulDiv  input  1  ID instruction is mult/multu/div/divu
- ID_ReadHiLo  input  1  ID instruction is mfhi/mflo
- EX_MemRead  input  1  EX instruction is a load
- EX_WR_out  input  5  destination register of the EX instruction
- EX_BranchTaken  input  1  branch/jump in EX resolved taken
- PC_Write  output  1  PC update enable
- IF_ID_Write  output  1  IF_ID register enable
- IF_ID_Flush  output  1  zero the IF_ID register (insert nop)
- ID_EX_Flush  output  1  zero the ID_EX control bits (insert bubble)
- MD_Start  output  1  single-cycle start pulse to the MUL/DIV unit
- MD_Busy  output  1  MUL/DIV operation in flight
- Stall_Count  output  CNT_W  number of cycles in which stall was asserted

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset:
  - state=IDLE, busy counter=0, Stall_Count=0.
  - While rst=1, outputs are forced to: PC_Write=1, IF_ID_Write=1, IF_ID_Flush=0, ID_EX_Flush=0, MD_Start=0, MD_Busy=0.
  - Reset mid-operation aborts BUSY immediately. There is no pending start.
- Decision outputs are combinational from the inputs and the current state, with zero latency. Registers update on the rising edge of clk.
- load_use = EX_MemRead & (EX_WR_out!=0) & ((ID_UseRs & EX_WR_out==ID_Rs) | (ID_UseRt & EX_WR_out==ID_Rt)).
- md_hazard = MD_Busy & (ID_MulDiv | ID_ReadHiLo).
- stall = ~EX_BranchTaken & (load_use | md_hazard).
- Priority: branch > stall > normal.
  - Branch: IF_ID_Flush=1, ID_EX_Flush=1, PC_Write=1, IF_ID_Write=1, MD_Start=0. The squashed ID instruction never starts MUL/DIV and never stalls.
  - Stall: PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1, IF_ID_Flush=0.
  - Normal: PC_Write=1, IF_ID_Write=1, both flushes=0.
- MUL/DIV FSM:
  - IDLE: MD_Busy=0.
    - MD_Start = ID_MulDiv & ~stall & ~EX_BranchTaken.
    - If MD_Start is asserted: next state BUSY, counter loads MD_LAT-1.
  - BUSY: MD_Busy=1, MD_Start=0.
    - Counter decrements each cycle.
    - In the cycle with counter==0, state is still BUSY. Next state is IDLE.
    - Result: BUSY lasts exactly MD_LAT cycles.
  - A MUL/DIV arriving in ID during BUSY stalls. It starts in the first IDLE cycle, giving back-to-back operations with no overlap.
  - Independent instructions flow normally during BUSY.
  - EX_BranchTaken during BUSY does not abort the in-flight operation.
- Stall_Count: increments by 1 on every edge where stall=1 and rst=0. It saturates at all-ones and does not wrap.
- Simultaneous load_use and md_hazard count as one stall cycle.
- Register $0 is never a hazard source.

Test Plan:
- Load-use: EX_MemRead=1, EX_WR_out=8, ID_Rs=8, ID_UseRs=1 for one cycle -> PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1 that cycle; Stall_Count 0->1. Repeat with EX_WR_out=0 -> no stall, Stall_Count stays.
- MUL then mfhi (MD_LAT=4): ID_MulDiv=1 at cycle t -> MD_Start=1 at t; MD_Busy=1 for t+1..t+4. Hold ID_ReadHiLo=1 from t+1 -> stall for exactly 4 cycles, released at t+5; Stall_Count=4.
- Branch priority: EX_BranchTaken=1 together with load_use and ID_MulDiv=1 in IDLE -> IF_ID_Flush=1, ID_EX_Flush=1, PC_Write=1, MD_Start=0, no stall count, state stays IDLE.
- Back-to-back MUL/DIV: second ID_MulDiv held during BUSY -> stalled until first IDLE cycle. Then MD_Start=1 again and a second 4-cycle BUSY; MD_Start never asserted while MD_Busy=1.
- Reset mid-BUSY: rst=1 at second BUSY cycle -> next cycle MD_Busy=0 and Stall_Count=0. After rst drops, a pending mfhi proceeds with no stall.
- Saturation (CNT_W=4 build): hold load_use 20 cycles -> Stall_Count reaches 15 and holds 15.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Decode-stage hazard/stall controller: load-use and MUL/DIV interlocks,
// taken-branch squash, MUL/DIV busy sequencer and a saturating stall counter.
module hazard_ctrl #(
  parameter int MD_LAT = 4,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       ID_Rs,
  input  logic [4:0]       ID_Rt,
  input  logic             ID_UseRs,
  input  logic             ID_UseRt,
  input  logic             ID_MulDiv,
  input  logic             ID_ReadHiLo,
  input  logic             EX_MemRead,
  input  logic [4:0]       EX_WR_out,
  input  logic             EX_BranchTaken,
  output logic             PC_Write,
  output logic             IF_ID_Write,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Flush,
  output logic             MD_Start,
  output logic             MD_Busy,
  output logic [CNT_W-1:0] Stall_Count,
  output logic             o_dbg_state
);

  localparam int CW = (MD_LAT > 2) ? $clog2(MD_LAT) : 1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic [CNT_W-1:0] r_stall_cnt;

  logic w_load_use;
  logic w_md_hazard;
  logic w_stall;
  logic w_busy;
  logic w_start;

  // Register $0 is hardwired zero, so a load targeting it never creates a dependency.
  assign w_load_use = EX_MemRead && (EX_WR_out != 5'd0) &&
                      ((ID_UseRs && (EX_WR_out == ID_Rs)) ||
                       (ID_UseRt && (EX_WR_out == ID_Rt)));

  assign w_busy      = !rst && (r_state == S_BUSY);
  assign w_md_hazard = w_busy && (ID_MulDiv || ID_ReadHiLo);
  assign w_stall     = !rst && !EX_BranchTaken && (w_load_use || w_md_hazard);
  assign w_start     = !rst && (r_state == S_IDLE) && ID_MulDiv &&
                       !w_stall && !EX_BranchTaken;

  always_comb begin
    PC_Write    = 1'b1;
    IF_ID_Write = 1'b1;
    IF_ID_Flush = 1'b0;
    ID_EX_Flush = 1'b0;
    if (!rst) begin
      if (EX_BranchTaken) begin
        IF_ID_Flush = 1'b1;
        ID_EX_Flush = 1'b1;
      end else if (w_stall) begin
        PC_Write    = 1'b0;
        IF_ID_Write = 1'b0;
        ID_EX_Flush = 1'b1;
      end
    end
  end

  assign MD_Start    = w_start;
  assign MD_Busy     = w_busy;
  assign Stall_Count = r_stall_cnt;
  assign o_dbg_state = r_state;

  // BUSY spans MD_LAT cycles: loaded with MD_LAT-1, leaves after the zero cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_state_nxt = S_BUSY;
          w_cnt_nxt   = CW'(MD_LAT - 1);
        end
      end
      S_BUSY: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_stall && !(&r_stall_cnt)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
    end
  end

endmodule
